onehot_req_arbiter: RTL and testbench

- Round-robin arbiter that collects single-cycle request pulses from 8 sources and issues one registered one-hot grant at a time.
- Sits directly upstream of the 8-to-3 encoder: its grant vector drives the encoder's I[7:0] input, so the encoder always sees a legal one-hot value or zero.
- Each grant is held stable until the downstream consumer acknowledges it.

---
 rtl/onehot_req_arbiter_if.sv | 35 +++
 rtl/onehot_req_arbiter.sv | 99 +++++++++
 tb/tb_onehot_req_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/onehot_req_arbiter_if.sv
// Request/grant bundle between the request sources, the arbiter and the downstream encoder.
// Defining ONEHOT_ARB_GRANT_CODE_EN adds the registered binary grant index grant_code.
interface onehot_req_arbiter_if #(
  parameter int N     = 8,
  parameter int PTR_W = 3
);
  logic [N-1:0]     req_in;
  logic             grant_ack;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [N-1:0]     pend;
  logic [PTR_W-1:0] ptr;
  logic             merge_err;
`ifdef ONEHOT_ARB_GRANT_CODE_EN
  logic [PTR_W-1:0] grant_code;

  modport master (
    output req_in, grant_ack,
    input  grant, grant_valid, pend, ptr, merge_err, grant_code
  );
  modport slave (
    input  req_in, grant_ack,
    output grant, grant_valid, pend, ptr, merge_err, grant_code
  );
`else
  modport master (
    output req_in, grant_ack,
    input  grant, grant_valid, pend, ptr, merge_err
  );
  modport slave (
    input  req_in, grant_ack,
    output grant, grant_valid, pend, ptr, merge_err
  );
`endif
endinterface

// File: rtl/onehot_req_arbiter.sv
// Round-robin arbiter turning single-cycle request pulses into a held one-hot grant.
// Optional ONEHOT_ARB_GRANT_CODE_EN also exports the registered binary grant index.
module onehot_req_arbiter #(
  parameter int N     = 8,
  parameter int PTR_W = 3
) (
  input logic                 clk,
  input logic                 rst,
  onehot_req_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [N-1:0]     clr;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] grantIdx_q, grantIdx_d;
  logic             mergeErr_q, mergeErr_d;
  logic             selFound;
  logic [PTR_W-1:0] selIdx;
  int               cand;

  // Circular scan of the registered pending vector starting at ptr.
  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    cand     = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!selFound && pend_q[cand]) begin
        selFound = 1'b1;
        selIdx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grantIdx_d = grantIdx_q;
    ptr_d      = ptr_q;
    clr        = '0;
    case (state_q)
      IDLE: begin
        grant_d    = '0;
        grantIdx_d = '0;
        if (selFound) begin
          grant_d[selIdx] = 1'b1;
          grantIdx_d      = selIdx;
          state_d         = GRANT;
        end
      end
      GRANT: begin
        if (bus.grant_ack) begin
          clr        = grant_q;
          ptr_d      = (grantIdx_q == PTR_W'(N - 1)) ? '0 : grantIdx_q + PTR_W'(1);
          grant_d    = '0;
          grantIdx_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new pulse on the bit being cleared keeps it pending.
    pend_d     = (pend_q & ~clr) | bus.req_in;
    mergeErr_d = mergeErr_q | (|(bus.req_in & pend_q & ~clr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      grant_q    <= '0;
      grantIdx_q <= '0;
      ptr_q      <= '0;
      mergeErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      grant_q    <= grant_d;
      grantIdx_q <= grantIdx_d;
      ptr_q      <= ptr_d;
      mergeErr_q <= mergeErr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = (state_q == GRANT);
  assign bus.pend        = pend_q;
  assign bus.ptr         = ptr_q;
  assign bus.merge_err   = mergeErr_q;
`ifdef ONEHOT_ARB_GRANT_CODE_EN
  assign bus.grant_code  = grantIdx_q;
`endif

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Directed, table-driven bench for onehot_req_arbiter (N=8).
// Exercises grant_code as well when ONEHOT_ARB_GRANT_CODE_EN is defined.
module tb_onehot_req_arbiter;

  typedef struct {
    logic [7:0] req;
    logic       ack;
    logic [7:0] grant;
    logic       gv;
    logic [7:0] pend;
    logic [2:0] ptr;
    logic       merr;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[26];

  onehot_req_arbiter_if #(.N(8), .PTR_W(3)) bus ();

  onehot_req_arbiter #(.N(8), .PTR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eGrant, input logic eGv,
                             input logic [7:0] ePend, input logic [2:0] ePtr, input logic eMerr);
    cmp({name, ".grant"}, bus.grant, eGrant);
    cmp({name, ".grant_valid"}, {7'b0, bus.grant_valid}, {7'b0, eGv});
    cmp({name, ".pend"}, bus.pend, ePend);
    cmp({name, ".ptr"}, {5'b0, bus.ptr}, {5'b0, ePtr});
    cmp({name, ".merge_err"}, {7'b0, bus.merge_err}, {7'b0, eMerr});
  endtask

  task automatic applyStimulus(input logic [7:0] req, input logic ack);
    bus.req_in    = req;
    bus.grant_ack = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // req, ack -> grant, grant_valid, pend, ptr, merge_err after the edge
    vecs[0]  = '{8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 3'd0, 1'b0};
    vecs[1]  = '{8'h00, 1'b0, 8'h04, 1'b1, 8'h04, 3'd0, 1'b0};
    vecs[2]  = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0};
    vecs[3]  = '{8'h0B, 1'b0, 8'h00, 1'b0, 8'h0B, 3'd3, 1'b0};
    vecs[4]  = '{8'h00, 1'b0, 8'h08, 1'b1, 8'h0B, 3'd3, 1'b0};
    vecs[5]  = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h03, 3'd4, 1'b0};
    vecs[6]  = '{8'h00, 1'b0, 8'h01, 1'b1, 8'h03, 3'd4, 1'b0};
    vecs[7]  = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h02, 3'd1, 1'b0};
    vecs[8]  = '{8'h00, 1'b0, 8'h02, 1'b1, 8'h02, 3'd1, 1'b0};
    vecs[9]  = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0};
    vecs[10] = '{8'h81, 1'b0, 8'h00, 1'b0, 8'h81, 3'd2, 1'b0};
    vecs[11] = '{8'h00, 1'b0, 8'h80, 1'b1, 8'h81, 3'd2, 1'b0};
    vecs[12] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0};
    vecs[13] = '{8'h00, 1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b0};
    vecs[14] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd1, 1'b0};
    vecs[15] = '{8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 3'd1, 1'b0};
    vecs[16] = '{8'h00, 1'b0, 8'h04, 1'b1, 8'h04, 3'd1, 1'b0};
    vecs[17] = '{8'h04, 1'b1, 8'h00, 1'b0, 8'h04, 3'd3, 1'b0};
    vecs[18] = '{8'h00, 1'b0, 8'h04, 1'b1, 8'h04, 3'd3, 1'b0};
    vecs[19] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0};
    vecs[20] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0};
    vecs[21] = '{8'h03, 1'b0, 8'h00, 1'b0, 8'h03, 3'd3, 1'b0};
    vecs[22] = '{8'h02, 1'b0, 8'h01, 1'b1, 8'h03, 3'd3, 1'b1};
    vecs[23] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h02, 3'd1, 1'b1};
    vecs[24] = '{8'h00, 1'b0, 8'h02, 1'b1, 8'h02, 3'd1, 1'b1};
    vecs[25] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd2, 1'b1};

    rst           = 1'b1;
    bus.req_in    = 8'h00;
    bus.grant_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].req, vecs[i].ack);
      checkOutput($sformatf("vec%0d", i), vecs[i].grant, vecs[i].gv,
                  vecs[i].pend, vecs[i].ptr, vecs[i].merr);
    end

    // Grant held without ack while a new request arrives; then wrap from index 6 to 4.
    applyStimulus(8'h40, 1'b0);
    checkOutput("hold_req", 8'h00, 1'b0, 8'h40, 3'd2, 1'b1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("hold_grant", 8'h40, 1'b1, 8'h40, 3'd2, 1'b1);
`ifdef ONEHOT_ARB_GRANT_CODE_EN
    cmp("grant_code_6", {5'b0, bus.grant_code}, 8'd6);
`endif
    applyStimulus(8'h10, 1'b0);
    checkOutput("hold_newreq", 8'h40, 1'b1, 8'h50, 3'd2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(8'h00, 1'b0);
      checkOutput($sformatf("hold_stable%0d", c), 8'h40, 1'b1, 8'h50, 3'd2, 1'b1);
    end
    applyStimulus(8'h00, 1'b1);
    checkOutput("hold_ack", 8'h00, 1'b0, 8'h10, 3'd7, 1'b1);
`ifdef ONEHOT_ARB_GRANT_CODE_EN
    cmp("grant_code_idle", {5'b0, bus.grant_code}, 8'd0);
`endif
    applyStimulus(8'h00, 1'b0);
    checkOutput("wrap_grant4", 8'h10, 1'b1, 8'h10, 3'd7, 1'b1);
`ifdef ONEHOT_ARB_GRANT_CODE_EN
    cmp("grant_code_4", {5'b0, bus.grant_code}, 8'd4);
`endif

    // Asynchronous reset mid-grant with all requests asserted.
    applyStimulus(8'h22, 1'b0);
    #3;
    bus.req_in = 8'hFF;
    rst        = 1'b1;
    #1;
    checkOutput("async_reset", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
`ifdef ONEHOT_ARB_GRANT_CODE_EN
    cmp("grant_code_reset", {5'b0, bus.grant_code}, 8'd0);
`endif
    bus.req_in = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0);
    checkOutput("post_reset", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
